// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control FSM of the multicycle RV32I core. It decodes the latched
//   instruction fields and steps the datapath one state per clock. It is the
//   producer end of the ALU control interface: it drives the 4-bit ALU select
//   code and consumes the ALU zero flag to resolve branches.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   opcode[6:0]  in   instr[6:0]
//   funct3[2:0]  in   instr[14:12]
//   funct7b5     in   instr[30]
//   zero         in   ALU zero flag (only looked at in BRANCH)
//   pc_write     out  PC load enable
//   adr_src      out  memory address mux: 0 = PC, 1 = result
//   mem_write    out  data memory write enable
//   ir_write     out  instruction / old-PC register load enable
//   reg_write    out  register file write enable
//   result_src   out  00 ALUOut, 01 memory data, 10 ALU result, 11 immediate
//   alu_src_a    out  00 PC, 01 old PC, 10 rs1
//   alu_src_b    out  00 rs2, 01 immediate, 10 constant 4
//   alu_control  out  ALU select code
//   illegal      out  sticky illegal-instruction flag
//
// Build option
//   CTRL_ILLEGAL_TRAP_EN  when defined, unknown opcodes and branch funct3
//                         010/011 park the FSM in ILLEGAL until reset.
//                         When undefined, unknown opcodes are a 2-cycle NOP,
//                         those branches are simply not taken, and illegal=0.
//
// State table
//   state     | meaning
//   FETCH     | read instruction at PC, PC <= PC + 4
//   DECODE    | read registers, ALUOut <= oldPC + imm (branch/JAL target)
//   MEMADR    | ALUOut <= rs1 + imm (load/store address)
//   MEMREAD   | read data memory at ALUOut
//   MEMWB     | rd <= memory data
//   MEMWRITE  | write rs2 to data memory at ALUOut
//   EXECR     | ALUOut <= rs1 op rs2
//   EXECI     | ALUOut <= rs1 op imm
//   ALUWB     | rd <= ALUOut
//   BRANCH    | compare rs1/rs2, PC <= ALUOut when taken
//   JAL       | PC <= ALUOut (target), ALUOut <= oldPC + 4
//   JALR      | ALUOut <= rs1 + imm (target)
//   JALR2     | PC <= ALUOut (target), ALUOut <= oldPC + 4
//   LUI       | rd <= immediate
//   AUIPC     | ALUOut <= oldPC + imm
//   ILLEGAL   | trapped on a bad instruction, waits for reset (option only)

module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic       illegal
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13,
`ifdef CTRL_ILLEGAL_TRAP_EN
    S_AUIPC    = 4'd14,
    S_ILLEGAL  = 4'd15
`else
    S_AUIPC    = 4'd14
`endif
  } state_t;

  state_t state;
  state_t state_next;
  state_t state_eff;

  // Register/immediate ALU op decode. funct7b5 selects SUB only for
  // register operands (ADDI has no SUBI), but selects SRA for both.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                            input logic       f7b5,
                                            input logic       is_reg);
    logic [3:0] code;
    code = ALU_ADD;
    case (f3)
      3'b000:  code = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  // Branch compare code and taken condition. SLT/SLTU produce 1 when
  // rs1 < rs2, so "less than" is taken on a non-zero result.
  logic [3:0] br_alu;
  logic       br_taken;
  logic       br_bad;

  always_comb begin
    br_alu   = ALU_ADD;
    br_taken = 1'b0;
    br_bad   = 1'b0;
    case (funct3)
      3'b000:  begin br_alu = ALU_SUB;  br_taken = zero;  end
      3'b001:  begin br_alu = ALU_SUB;  br_taken = !zero; end
      3'b100:  begin br_alu = ALU_SLT;  br_taken = !zero; end
      3'b101:  begin br_alu = ALU_SLT;  br_taken = zero;  end
      3'b110:  begin br_alu = ALU_SLTU; br_taken = !zero; end
      3'b111:  begin br_alu = ALU_SLTU; br_taken = zero;  end
      default: br_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // While reset is held the outputs already show FETCH, so an aborted
  // instruction cannot emit a stray write strobe in the reset cycle.
  assign state_eff = reset ? S_FETCH : state;

  logic illegal_q;

  always_comb begin
    state_next  = S_FETCH;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RS2;
    alu_control = ALU_ADD;
    illegal_q   = 1'b0;

    case (state_eff)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        pc_write   = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_LOAD,
          OP_STORE:  state_next = S_MEMADR;
          OP_RTYPE:  state_next = S_EXECR;
          OP_ITYPE:  state_next = S_EXECI;
          OP_BRANCH: state_next = S_BRANCH;
          OP_JAL:    state_next = S_JAL;
          OP_JALR:   state_next = S_JALR;
          OP_LUI:    state_next = S_LUI;
          OP_AUIPC:  state_next = S_AUIPC;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:   state_next = S_ILLEGAL;
`else
          default:   state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        mem_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_RS2;
        alu_control = alu_decode(funct3, funct7b5, 1'b1);
        state_next  = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_IMM;
        alu_control = alu_decode(funct3, funct7b5, 1'b0);
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_RS2;
        result_src  = RES_ALUOUT;
        alu_control = br_alu;
        pc_write    = br_taken;
`ifdef CTRL_ILLEGAL_TRAP_EN
        state_next  = br_bad ? S_ILLEGAL : S_FETCH;
`else
        state_next  = S_FETCH;
`endif
      end
      S_JAL, S_JALR2: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        state_next = S_JALR2;
      end
      S_LUI: begin
        result_src = RES_IMM;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_AUIPC: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_IMM;
        state_next = S_ALUWB;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_ILLEGAL: begin
        illegal_q  = 1'b1;
        state_next = S_ILLEGAL;
      end
`endif
      default: state_next = S_FETCH;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal = illegal_q;
`else
  // br_bad only matters for the trap; the flag is unused without it.
  logic unused_ok;
  assign unused_ok = br_bad | illegal_q;
  assign illegal   = 1'b0;
`endif

endmodule
